silly_function: RTL and testbench
=================================

Name: silly_function

Overview:
- Three-input Boolean function block: y = (a & ~b) | (~b & ~c).
- The combinational output y is purely combinational and is the primary output used by downstream logic and unit benches.
- The block also provides:
  - a registered copy of the result with a valid qualifier;
  - a saturating count of asserted registered results, for on-chip self-check and debug.

Parameters:
- COUNT_W, 16, width of the ones counter (minimum 2).

Ports:
- clk  input  1  rising-edge clock for the registered path.
- reset  input  1  asynchronous, active-low reset (asserted at 0) for all registers.
- a  input  1  function input, MSB of index {a,b,c}.
- b  input  1  function input, middle bit.
- c  input  1  function input, LSB.
- y  output  1  combinational function result.
- in_valid  input  1  qualifies a/b/c for capture into the registered path.
- y_q  output  1  registered result of the captured inputs.
- out_valid  output  1  y_q holds a fresh result this cycle.
- clear  input  1  synchronous clear of ones_count.
- ones_count  output  COUNT_W  number of captured results equal to 1, saturating.

Behaviour:
- Combinational path y, indexed by {a,b,c}:
  - 000→1, 001→0, 010→0, 011→0, 100→1, 101→1, 110→0, 111→0.
  - Equivalently, the truth-table constant 8'h31 indexed by {a,b,c}.
  - y depends only on a, b, c. It is independent of clk, reset, in_valid and clear, and is valid during reset.
- Any X/Z on a, b or c may propagate to y; no masking.
- Reset (reset == 0, asynchronous assert; deassertion is sampled on the clk edge): y_q = 0, out_valid = 0, ones_count = 0.
- Registered path, on each rising clk when reset == 1:
  - out_valid <= in_valid.
  - If in_valid: y_q <= f(a,b,c).
  - Otherwise y_q holds its previous value.
- Latency: exactly 1 clock from input capture to y_q/out_valid. There is no backpressure; every valid input is accepted.
- Counter, on each rising clk when reset == 1:
  - If clear: ones_count <= 0. clear has priority over a simultaneous increment.
  - Else if in_valid and f(a,b,c) == 1 and ones_count != all-ones: ones_count <= ones_count + 1.
  - The counter counts the same captures that load y_q; its update is coincident with y_q's.
- Saturation: at 2^COUNT_W − 1, ones_count holds and never wraps.
- Reset asserted mid-operation clears y_q, out_valid and ones_count immediately (asynchronously). y continues to track the inputs.
- No internal state affects y. The registered path must not alter combinational timing of y.

Test Plan:
- Exhaustive combinational sweep, for each {a,b,c}:
  - apply each of 000..111 sequentially, inputs changed 1 time unit after posedge and checked at negedge;
  - y must equal 1,0,0,0,1,1,0,0 respectively;
  - use case-equality compare; zero errors over 8 vectors.
- Reset behaviour:
  - hold reset = 0 for 27 time units with a clock period of 10;
  - y_q = 0, out_valid = 0 and ones_count = 0 throughout;
  - y still tracks the inputs, e.g. {a,b,c} = 100 → y = 1.
- Registered latency:
  - with reset = 1, drive in_valid = 1 and {a,b,c} = 101 for one cycle, then in_valid = 0;
  - the next cycle shows y_q = 1, out_valid = 1;
  - the following cycle shows out_valid = 0 with y_q held at 1.
- Counter accumulation:
  - drive all 8 vectors with in_valid = 1;
  - after the last capture ones_count = 3, i.e. the captures of vectors 000, 100 and 101.
- Clear priority and saturation:
  - with COUNT_W = 2, repeatedly capture 000; ones_count reaches 3 and holds;
  - assert clear together with a capture of 100; the next cycle ones_count = 0.
- Asynchronous reset mid-stream:
  - assert reset = 0 between clock edges while ones_count = 2;
  - ones_count, y_q and out_valid go to 0 before the next clk edge.

Source files
------------

// File: rtl/silly_function.sv
// Three-input Boolean function y = (a & ~b) | (~b & ~c), with a registered copy
// of captured results and a saturating count of captured ones.
module silly_function #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a,
    input  logic               b,
    input  logic               c,
    output logic               y,
    input  logic               in_valid,
    output logic               y_q,
    output logic               out_valid,
    input  logic               clear,
    output logic [COUNT_W-1:0] ones_count
);

    // Truth table indexed by {a,b,c}: ones at 000, 100 and 101.
    localparam logic [7:0] TRUTH = 8'h31;

    logic [2:0] idx;

    assign idx = {a, b, c};
    assign y   = TRUTH[idx];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_q       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y_q <= y;
            end
        end
    end

    // Counts the same captures that load y_q; clear wins over an increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ones_count <= '0;
        end else if (clear) begin
            ones_count <= '0;
        end else if (in_valid && y && (ones_count != '1)) begin
            ones_count <= ones_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_silly_function.sv
// Self-checking bench for silly_function: vector table for the combinational
// sweep, scoreboard queue for the registered path, and directed corner cases.
module tb_silly_function;

    logic        clk;
    logic        reset;
    logic        a, b, c;
    logic        in_valid;
    logic        clear;
    logic        y, y_q, out_valid;
    logic [15:0] ones_count;
    logic        y_s, y_q_s, out_valid_s;
    logic [1:0]  ones_count_s;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] abc;
        logic       exp_y;
    } vec_t;

    typedef struct {
        logic        yq;
        logic        ov;
        logic [15:0] cnt;
        logic [1:0]  cnt_s;
    } exp_t;

    exp_t        sb[$];
    logic        ref_yq;
    logic        ref_ov;
    logic [15:0] ref_cnt;
    logic [1:0]  ref_cnt_s;

    silly_function dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .c          (c),
        .y          (y),
        .in_valid   (in_valid),
        .y_q        (y_q),
        .out_valid  (out_valid),
        .clear      (clear),
        .ones_count (ones_count)
    );

    silly_function #(.COUNT_W(2)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .c          (c),
        .y          (y_s),
        .in_valid   (in_valid),
        .y_q        (y_q_s),
        .out_valid  (out_valid_s),
        .clear      (clear),
        .ones_count (ones_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_f(input logic [2:0] v);
        return (v[2] & ~v[1]) | (~v[1] & ~v[0]);
    endfunction

    // Called at posedge+1: drive, push the expected post-edge state, check y
    // at negedge, then compare the registered outputs just after the edge.
    task automatic step(input logic [2:0] v, input logic iv, input logic clr);
        exp_t e;
        logic fy;
        {a, b, c} = v;
        in_valid  = iv;
        clear     = clr;
        fy = ref_f(v);
        if (iv) ref_yq = fy;
        ref_ov = iv;
        if (clr) begin
            ref_cnt   = '0;
            ref_cnt_s = '0;
        end else if (iv && fy) begin
            if (ref_cnt != 16'hffff) ref_cnt++;
            if (ref_cnt_s != 2'b11) ref_cnt_s++;
        end
        e.yq = ref_yq; e.ov = ref_ov; e.cnt = ref_cnt; e.cnt_s = ref_cnt_s;
        sb.push_back(e);
        @(negedge clk);
        check("y_step", 32'(y), 32'(fy));
        check("y_sat_step", 32'(y_s), 32'(fy));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("y_q", 32'(y_q), 32'(e.yq));
            check("out_valid", 32'(out_valid), 32'(e.ov));
            check("ones_count", 32'(ones_count), 32'(e.cnt));
            check("y_q_sat", 32'(y_q_s), 32'(e.yq));
            check("out_valid_sat", 32'(out_valid_s), 32'(e.ov));
            check("ones_count_sat", 32'(ones_count_s), 32'(e.cnt_s));
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_y_q"}, 32'(y_q), 32'd0);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_ones_count"}, 32'(ones_count), 32'd0);
        check({name, "_ones_count_sat"}, 32'(ones_count_s), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        vecs[0] = '{3'b000, 1'b1};
        vecs[1] = '{3'b001, 1'b0};
        vecs[2] = '{3'b010, 1'b0};
        vecs[3] = '{3'b011, 1'b0};
        vecs[4] = '{3'b100, 1'b1};
        vecs[5] = '{3'b101, 1'b1};
        vecs[6] = '{3'b110, 1'b0};
        vecs[7] = '{3'b111, 1'b0};

        ref_yq = 1'b0; ref_ov = 1'b0; ref_cnt = '0; ref_cnt_s = '0;

        // Reset held for 27 time units; y must still track inputs.
        reset = 1'b0;
        {a, b, c} = 3'b100;
        in_valid = 1'b1;
        clear = 1'b0;
        #3;
        check_reset_state("rst_t3");
        check("rst_y_100", 32'(y), 32'd1);
        @(negedge clk);
        check_reset_state("rst_t10");
        {a, b, c} = 3'b011;
        #1;
        check("rst_y_011", 32'(y), 32'd0);
        @(negedge clk);
        check_reset_state("rst_t20");
        #6;
        check_reset_state("rst_t26");
        in_valid = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Exhaustive sweep with capture; counter accumulates 000, 100, 101.
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].abc, 1'b1, 1'b0);
            check($sformatf("table_y_%0d", i), 32'(y), 32'(vecs[i].exp_y));
        end
        check("sweep_count", 32'(ones_count), 32'd3);

        // Latency: capture 101, then idle; y_q holds.
        step(3'b101, 1'b1, 1'b0);
        check("lat_y_q", 32'(y_q), 32'd1);
        check("lat_ov", 32'(out_valid), 32'd1);
        step(3'b011, 1'b0, 1'b0);
        check("lat_ov_drop", 32'(out_valid), 32'd0);
        check("lat_y_q_held", 32'(y_q), 32'd1);

        // Saturation of the 2-bit counter while the 16-bit one keeps counting.
        for (int i = 0; i < 3; i++) step(3'b000, 1'b1, 1'b0);
        check("sat_hold", 32'(ones_count_s), 32'd3);
        check("wide_count", 32'(ones_count), 32'd7);

        // Clear wins over a simultaneous counting capture.
        step(3'b100, 1'b1, 1'b1);
        check("clear_prio", 32'(ones_count), 32'd0);
        check("clear_prio_sat", 32'(ones_count_s), 32'd0);
        check("clear_y_q", 32'(y_q), 32'd1);

        // Asynchronous reset between edges with ones_count = 2.
        step(3'b000, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);
        check("pre_async_count", 32'(ones_count), 32'd2);
        in_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check_reset_state("async");
        {a, b, c} = 3'b101;
        #1;
        check("async_y_tracks", 32'(y), 32'd1);
        ref_yq = 1'b0; ref_ov = 1'b0; ref_cnt = '0; ref_cnt_s = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("post_async");
        step(3'b100, 1'b1, 1'b0);
        check("recover_count", 32'(ones_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
